xadc_drp_master: RTL and testbench
==================================

# xadc_drp_master

Write-capable master for the XADC dynamic reconfiguration port (DRP), the write-side counterpart of the joystick sample reader. After reset it programs the XADC sequencer for auxiliary channels 6 and 15 (continuous sequence mode). It then serves single read/write commands from fabric logic over a valid/ready handshake with a bounded wait for `drdy`. It sits between control logic (drone/joystick tuning, status readback) and the XADC primitive's DRP pins.

## Interface
- `INIT_SEQ_SEL`, 16'h8040: value written to DRP address 7'h49, selecting channel bits 6 and 15.
- `INIT_CFG0`, 16'h0000: value written to DRP address 7'h40.
- `INIT_CFG1`, 16'h2000: value written to DRP address 7'h41, selecting continuous sequence mode.
- `TIMEOUT_CYC`, 255: maximum number of wait cycles for `drdy` after `den`, range 1..1023.

- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  master can accept a command; high only in IDLE.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  7  DRP register address.
- `cmd_wdata`  in  16  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  16  `do` captured at `drdy`; 0 on timeout.
- `rsp_err`  out  1  valid with `rsp_valid`; 1 = timeout.
- `init_done`  out  1  set when the init sequence finishes; stays set until reset.
- `init_err`  out  1  sticky; 1 if any init write timed out.
- `daddr`  out  7  DRP address.
- `den`  out  1  DRP enable, one-cycle pulse.
- `dwe`  out  1  DRP write enable; qualified by `den`.
- `di`  out  16  DRP write data.
- `do`  in  16  DRP read data.
- `drdy`  in  1  DRP ready.

## Operation
- States:
  - INIT_ISSUE: drive one init write.
  - INIT_WAIT: wait for that write to complete.
  - IDLE: ready for a command.
  - ISSUE: drive the accepted command.
  - WAIT: wait for `drdy`.
- Reset:
  - Outputs all 0; `daddr` and `di` are 0.
  - State goes to INIT_ISSUE.
  - Init index and timeout counter clear to 0.
- Init sequence: three writes, in order (7'h49, `INIT_SEQ_SEL`), (7'h40, `INIT_CFG0`), (7'h41, `INIT_CFG1`).
- INIT_ISSUE:
  - Drive `den`=1, `dwe`=1, and `daddr`/`di` from the current table entry for exactly one cycle.
  - Then go to INIT_WAIT.
- INIT_WAIT:
  - On `drdy`, or when the timeout counter reaches `TIMEOUT_CYC`, advance the index.
  - On timeout, also set `init_err`.
  - If the index was 2, set `init_done` and go to IDLE; otherwise go back to INIT_ISSUE.
  - No `rsp_valid` pulses occur during init.
- IDLE:
  - `cmd_ready`=1.
  - When `cmd_valid` && `cmd_ready`, latch `cmd_we`/`cmd_addr`/`cmd_wdata` and go to ISSUE.
  - `drdy` is ignored in IDLE.
- ISSUE:
  - Drive `den`=1, `dwe`=latched `we`, `daddr`=latched address, `di`=latched data (0 for reads) for exactly one cycle.
  - Then go to WAIT.
- WAIT, on `drdy`:
  - Next cycle: `rsp_valid`=1, `rsp_err`=0, `rsp_rdata`=`do` sampled in the `drdy` cycle (writes also return `do`).
  - Go to IDLE.
- WAIT, on timeout:
  - Next cycle: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
  - Go to IDLE.
- Timeout counter:
  - 10-bit; cleared on entry to WAIT/INIT_WAIT.
  - Increments every wait cycle without `drdy`.
  - Times out on the cycle where count == `TIMEOUT_CYC` and `drdy`=0.
  - `drdy` in that same cycle wins: normal completion.
- `den` is never asserted while a transaction is outstanding. Exactly one `den` is issued per command.
- `daddr`/`di` hold their last values between transactions; `dwe` returns to 0 with `den`.
- Reset mid-transaction: abandon the transaction, drop all outputs to reset values, restart init. A late `drdy` arriving during the following INIT_ISSUE is ignored.

## Timing
- Command accepted at cycle T (`cmd_valid`&`cmd_ready`):
  - `cmd_ready` low from T+1.
  - `den` high at T+1.
  - WAIT from T+2.
- `drdy` at cycle D ≥ T+2: `rsp_valid` at D+1; `cmd_ready` high at D+1. Next command can be accepted at D+1.
- Minimum command-to-response latency is 3 cycles (`drdy` at T+2 → `rsp_valid` at T+3).
- Timeout: first WAIT cycle is T+2 (count 0) → timeout at T+2+`TIMEOUT_CYC` → `rsp_valid` (`rsp_err`=1) at T+3+`TIMEOUT_CYC`.
- Init after `reset_n` deasserts at cycle R:
  - First `den` at R+1.
  - With an immediate responder (`drdy` on the first wait cycle), each write takes 3 cycles.
  - `init_done` is high by R+9.

## Test plan
- Reset release with a DRP model giving `drdy` 2 cycles after `den` → three writes observed: 7'h49/16'h8040, 7'h40/16'h0000, 7'h41/16'h2000; then `init_done`=1, `init_err`=0, `cmd_ready`=1.
- After init, read `cmd_addr`=7'h16 (aux6), model returns 16'hA5C0 → single `den` with `dwe`=0, `daddr`=7'h16; one-cycle `rsp_valid`, `rsp_rdata`=16'hA5C0, `rsp_err`=0.
- Write 7'h49/16'h0040 with back-to-back `cmd_valid` held high → second command accepted only on the cycle of the first `rsp_valid`; `den` pulses never overlap an outstanding transaction.
- Model never asserts `drdy`, `TIMEOUT_CYC`=8 → `rsp_valid` at T+11 with `rsp_err`=1 and `rsp_rdata`=0; master returns to IDLE.
- Model silent during the second init write only → `init_err`=1, third write still issued, `init_done`=1.
- Assert `reset_n`=0 during WAIT, stray `drdy` during IDLE, and `drdy` on exactly the timeout cycle → respectively: outputs cleared and init restarted; no `rsp_valid`; normal completion with `rsp_err`=0.

Source files
------------

// File: rtl/xadc_drp_master_if.sv
// Command/response handshake plus XADC DRP pins for xadc_drp_master.
// `do` is a reserved word, so the DRP read-data bus is carried as drp_do.
interface xadc_drp_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] drp_do;
  logic        drdy;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, drp_do, drdy,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, daddr, den, dwe, di
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, drp_do, drdy,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, daddr, den, dwe, di
  );
endinterface

// File: rtl/xadc_drp_master.sv
// XADC DRP master: programs the sequencer for aux channels 6/15 after reset,
// then serves single read/write commands with a bounded wait for drdy.
module xadc_drp_master #(
  parameter logic [15:0] INIT_SEQ_SEL = 16'h8040,
  parameter logic [15:0] INIT_CFG0    = 16'h0000,
  parameter logic [15:0] INIT_CFG1    = 16'h2000,
  parameter int unsigned TIMEOUT_CYC  = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  xadc_drp_master_if.master  bus,
  output logic               init_done,
  output logic               init_err
);
  typedef enum logic [2:0] {
    INIT_ISSUE,
    INIT_WAIT,
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [9:0] TMO = 10'(TIMEOUT_CYC);

  state_t      state, state_nx;
  logic [1:0]  idx, idx_nx;
  logic [9:0]  cnt, cnt_nx;
  logic        den_q, den_nx;
  logic        dwe_q, dwe_nx;
  logic [6:0]  daddr_q, daddr_nx;
  logic [15:0] di_q, di_nx;
  logic        rsp_valid_q, rsp_valid_nx;
  logic        rsp_err_q, rsp_err_nx;
  logic [15:0] rsp_rdata_q, rsp_rdata_nx;
  logic        done_q, done_nx;
  logic        err_q, err_nx;
  logic [6:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic        timeout;

  always_comb begin
    tbl_addr = 7'h49;
    tbl_data = INIT_SEQ_SEL;
    case (idx)
      2'd1: begin
        tbl_addr = 7'h40;
        tbl_data = INIT_CFG0;
      end
      2'd2: begin
        tbl_addr = 7'h41;
        tbl_data = INIT_CFG1;
      end
      default: ;
    endcase
  end

  // drdy on the terminal count still counts as a normal completion
  assign timeout = (cnt == TMO) && !bus.drdy;

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    cnt_nx       = cnt;
    den_nx       = 1'b0;
    dwe_nx       = 1'b0;
    daddr_nx     = daddr_q;
    di_nx        = di_q;
    rsp_valid_nx = 1'b0;
    rsp_err_nx   = 1'b0;
    rsp_rdata_nx = rsp_rdata_q;
    done_nx      = done_q;
    err_nx       = err_q;
    unique case (state)
      // First cycle loads the table entry into the output registers,
      // second cycle has den up; drdy is not looked at in either.
      INIT_ISSUE: begin
        if (!den_q) begin
          den_nx   = 1'b1;
          dwe_nx   = 1'b1;
          daddr_nx = tbl_addr;
          di_nx    = tbl_data;
        end else begin
          state_nx = INIT_WAIT;
          cnt_nx   = '0;
        end
      end
      INIT_WAIT: begin
        if (bus.drdy || timeout) begin
          if (timeout) err_nx = 1'b1;
          if (idx == 2'd2) begin
            done_nx  = 1'b1;
            idx_nx   = '0;
            state_nx = IDLE;
          end else begin
            idx_nx   = idx + 2'd1;
            state_nx = INIT_ISSUE;
          end
        end else begin
          cnt_nx = cnt + 10'd1;
        end
      end
      IDLE: begin
        if (bus.cmd_valid) begin
          den_nx   = 1'b1;
          dwe_nx   = bus.cmd_we;
          daddr_nx = bus.cmd_addr;
          di_nx    = bus.cmd_we ? bus.cmd_wdata : '0;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        state_nx = WAIT;
        cnt_nx   = '0;
      end
      WAIT: begin
        if (bus.drdy) begin
          rsp_valid_nx = 1'b1;
          rsp_rdata_nx = bus.drp_do;
          state_nx     = IDLE;
        end else if (timeout) begin
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b1;
          rsp_rdata_nx = '0;
          state_nx     = IDLE;
        end else begin
          cnt_nx = cnt + 10'd1;
        end
      end
      default: state_nx = INIT_ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= INIT_ISSUE;
      idx         <= '0;
      cnt         <= '0;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      daddr_q     <= '0;
      di_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      cnt         <= cnt_nx;
      den_q       <= den_nx;
      dwe_q       <= dwe_nx;
      daddr_q     <= daddr_nx;
      di_q        <= di_nx;
      rsp_valid_q <= rsp_valid_nx;
      rsp_err_q   <= rsp_err_nx;
      rsp_rdata_q <= rsp_rdata_nx;
      done_q      <= done_nx;
      err_q       <= err_nx;
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.den       = den_q;
  assign bus.dwe       = dwe_q;
  assign bus.daddr     = daddr_q;
  assign bus.di        = di_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign init_done     = done_q;
  assign init_err      = err_q;
endmodule

// File: tb/tb_xadc_drp_master.sv
// Bench for xadc_drp_master: DRP register-file responder with programmable
// drdy latency, and a cycle-level reference of the command/init timing.
module tb_xadc_drp_master;
  localparam int TO = 8;

  typedef struct {
    int          c;
    logic [6:0]  a;
    logic        we;
    logic [15:0] d;
  } den_t;

  typedef struct {
    int          c;
    logic [15:0] d;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic init_done;
  logic init_err;

  xadc_drp_master_if bus();

  xadc_drp_master #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .init_done (init_done),
    .init_err  (init_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] mem [128];
  logic [15:0] ref_mem [128];
  den_t        den_log [$];
  rsp_t        rsp_log [$];
  int          rsp_delay = 2;
  bit          silent_40 = 1'b0;
  bit          stray = 1'b0;
  int          cd = -1;
  logic [6:0]  pa = '0;
  bit          busy = 1'b0;
  bit          prev_den = 1'b0;
  bit          prev_done = 1'b0;
  int          done_cyc = -1;
  int          overlap_err = 0;

  // Monitor, then DRP responder: drdy arrives rsp_delay cycles after den
  always @(negedge clk) begin
    if (bus.den) begin
      den_log.push_back(den_t'{c: cyc, a: bus.daddr, we: bus.dwe, d: bus.di});
      if (busy || prev_den) overlap_err++;
      if (init_done) busy = 1'b1;
    end
    if (bus.rsp_valid) begin
      rsp_log.push_back(rsp_t'{c: cyc, d: bus.rsp_rdata, err: bus.rsp_err});
      busy = 1'b0;
    end
    if (!reset_n) busy = 1'b0;
    if (init_done && !prev_done) done_cyc = cyc;
    prev_done = init_done;
    prev_den  = bus.den;

    bus.drdy   = 1'b0;
    bus.drp_do = '0;
    if (cd > 0) cd--;
    if (cd == 0) begin
      cd         = -1;
      bus.drdy   = 1'b1;
      bus.drp_do = mem[pa];
    end else if (stray) begin
      stray      = 1'b0;
      bus.drdy   = 1'b1;
      bus.drp_do = 16'hdead;
    end
    if (bus.den) begin
      if (bus.dwe) mem[bus.daddr] = bus.di;
      if (rsp_delay != 0 && !(silent_40 && bus.daddr == 7'h40)) begin
        cd = rsp_delay;
        pa = bus.daddr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_init_ref();
    ref_mem[7'h49] = 16'h8040;
    ref_mem[7'h40] = 16'h0000;
    ref_mem[7'h41] = 16'h2000;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
    end
    chk("init_done", init_done, 1'b1);
  endtask

  task automatic wait_rsp(output rsp_t r);
    int n = 0;
    while (rsp_log.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    chk("rsp_seen", rsp_log.size(), 1);
    if (rsp_log.size() > 0) r = rsp_log.pop_front();
    else r = rsp_t'{c: -1, d: 16'hxxxx, err: 1'bx};
  endtask

  task automatic do_cmd(input logic we, input logic [6:0] a, input logic [15:0] wd, output int t);
    int n = 0;
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_accept", bus.cmd_ready, 1'b1);
    t = cyc;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // One command with responder latency d (0 = silent), checked against the
  // expected completion derived from the latency and the timeout budget.
  task automatic run_cmd(input logic we, input logic [6:0] a, input logic [15:0] wd, input int d);
    int t;
    int et;
    logic ee;
    logic [15:0] erd;
    rsp_t r;
    rsp_delay = d;
    den_log.delete();
    rsp_log.delete();
    do_cmd(we, a, wd, t);
    if (we) ref_mem[a] = wd;
    if (d >= 1 && d - 1 <= TO) begin
      et = t + 2 + d;  ee = 1'b0;  erd = ref_mem[a];
    end else begin
      et = t + 3 + TO; ee = 1'b1;  erd = '0;
    end
    wait_rsp(r);
    chk("rsp_cycle", r.c, et);
    chk("rsp_err", r.err, ee);
    chk("rsp_rdata", r.d, erd);
    chk("den_count", den_log.size(), 1);
    if (den_log.size() > 0) begin
      chk("den_cycle", den_log[0].c, t + 1);
      chk("den_addr", den_log[0].a, a);
      chk("den_we", den_log[0].we, we);
      chk("den_di", den_log[0].d, we ? wd : 16'h0000);
    end
    tick();
    tick();
    chk("rsp_single", rsp_log.size(), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_den", bus.den, 1'b0);
    chk("rst_dwe", bus.dwe, 1'b0);
    chk("rst_daddr", bus.daddr, 7'h00);
    chk("rst_di", bus.di, 16'h0000);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_init_err", init_err, 1'b0);
  endtask

  initial begin
    int   t1, t2, R, n, d;
    rsp_t r1, r2;
    logic we;
    logic [6:0] a;
    logic [15:0] wd;

    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[7'h16] = 16'hA5C0;
    for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
    apply_init_ref();

    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    repeat (4) tick();
    check_reset_outputs();

    // init with drdy two cycles after den
    rsp_delay = 2;
    den_log.delete();
    rsp_log.delete();
    R = cyc;
    reset_n = 1'b1;
    wait_init();
    tick();
    chk("init_den_count", den_log.size(), 3);
    if (den_log.size() == 3) begin
      chk("init0_cycle", den_log[0].c, R + 1);
      chk("init0", {den_log[0].we, den_log[0].a, den_log[0].d}, {1'b1, 7'h49, 16'h8040});
      chk("init1", {den_log[1].we, den_log[1].a, den_log[1].d}, {1'b1, 7'h40, 16'h0000});
      chk("init2", {den_log[2].we, den_log[2].a, den_log[2].d}, {1'b1, 7'h41, 16'h2000});
    end
    chk("init_done_cycle", done_cyc, R + 3 * (2 + 2));
    chk("init_err_clean", init_err, 1'b0);
    chk("ready_after_init", bus.cmd_ready, 1'b1);
    chk("no_rsp_in_init", rsp_log.size(), 0);

    run_cmd(1'b0, 7'h16, 16'h0000, 2);

    // back-to-back with cmd_valid held high
    rsp_delay = 3;
    den_log.delete();
    rsp_log.delete();
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_addr  = 7'h49;
    bus.cmd_wdata = 16'h0040;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin tick(); n++; end
    t1 = cyc;
    ref_mem[7'h49] = 16'h0040;
    tick();
    bus.cmd_we   = 1'b0;
    bus.cmd_addr = 7'h16;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin tick(); n++; end
    t2 = cyc;
    tick();
    bus.cmd_valid = 1'b0;
    chk("b2b_second_accept", t2, t1 + 2 + 3);
    wait_rsp(r1);
    chk("b2b_rsp1_cycle", r1.c, t1 + 5);
    chk("b2b_rsp1_data", {r1.err, r1.d}, {1'b0, 16'h0040});
    wait_rsp(r2);
    chk("b2b_rsp2_cycle", r2.c, t2 + 5);
    chk("b2b_rsp2_data", {r2.err, r2.d}, {1'b0, ref_mem[7'h16]});
    chk("b2b_den_count", den_log.size(), 2);

    // silent responder, then drdy on exactly the timeout cycle
    run_cmd(1'b0, 7'h10, 16'h0000, 0);
    chk("ready_after_timeout", bus.cmd_ready, 1'b1);
    run_cmd(1'b0, 7'h20, 16'h0000, TO + 1);
    run_cmd(1'b1, 7'h21, 16'h1234, TO + 1);

    // stray drdy while idle
    rsp_delay = 0;
    rsp_log.delete();
    stray = 1'b1;
    repeat (4) tick();
    chk("stray_no_rsp", rsp_log.size(), 0);
    chk("stray_ready", bus.cmd_ready, 1'b1);

    for (int i = 0; i < 16; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 7'($urandom_range(0, 127));
      wd = 16'($urandom);
      d  = int'($urandom_range(0, TO + 1));
      run_cmd(we, a, wd, d);
    end

    // second init write unanswered
    reset_n = 1'b0;
    repeat (2) tick();
    rsp_delay = 1;
    silent_40 = 1'b1;
    den_log.delete();
    rsp_log.delete();
    R = cyc;
    reset_n = 1'b1;
    wait_init();
    tick();
    silent_40 = 1'b0;
    apply_init_ref();
    chk("silent_init_err", init_err, 1'b1);
    chk("silent_den_count", den_log.size(), 3);
    if (den_log.size() == 3) chk("silent_third_addr", den_log[2].a, 7'h41);
    chk("silent_done_cycle", done_cyc, R + 3 + (TO + 3) + 3);
    chk("silent_no_rsp", rsp_log.size(), 0);

    // reset during WAIT; late drdy lands on the den cycle of the first init write
    rsp_delay = 4;
    do_cmd(1'b0, 7'h16, 16'h0000, t1);
    rsp_delay = 2;
    den_log.delete();
    rsp_log.delete();
    reset_n = 1'b0;
    tick();
    check_reset_outputs();
    tick();
    R = cyc;
    reset_n = 1'b1;
    wait_init();
    tick();
    chk("rst_restart_den0", den_log.size() > 0 ? den_log[0].c : -1, R + 1);
    chk("rst_restart_done", done_cyc, R + 12);
    chk("rst_restart_err", init_err, 1'b0);
    chk("rst_no_rsp", rsp_log.size(), 0);
    run_cmd(1'b0, 7'h49, 16'h0000, 1);

    chk("den_overlap", overlap_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
